// File: rtl/datapath_processor.sv
// Single-cycle MIPS-subset core with private instruction/data memories,
// a 32x32 register file, PC and a {V,C,N,Z} ALU status register.
// Memories and the register file are intentionally not reset; they are
// expected to be preloaded from outside before the program runs.
module datapath_processor #(
  parameter int IM_DEPTH = 32,
  parameter int DM_DEPTH = 32
) (
  input logic clk,
  input logic reset
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  logic [31:0] instmem      [0:IM_DEPTH-1];
  logic [31:0] datmem       [0:DM_DEPTH-1];
  logic [31:0] registerfile [0:31];
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] instruc;
  logic [3:0]  statusregister;
  logic [3:0]  status_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext_imm;
  logic [31:0] rs_val, rt_val;
  logic [31:0] pc_plus4, branch_target, jump_target;
  logic [31:0] add_b;
  logic [32:0] add_full, sub_full;
  logic        add_v, sub_v, slt_bit;
  logic [31:0] mem_addr;
  logic [4:0]  dm_idx;
  logic [31:0] dm_rdata;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dm_we;
  logic        flag_upd;
  logic [31:0] flag_res;
  logic        flag_c, flag_v;

  // Only bits [6:2] of PC and data addresses select a word; shamt is unused.
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[27:7], mem_addr[31:7], mem_addr[1:0], instruc[10:6]};

  assign instruc = instmem[pc[6:2]];
  assign op      = instruc[31:26];
  assign rs      = instruc[25:21];
  assign rt      = instruc[20:16];
  assign rd      = instruc[15:11];
  assign funct   = instruc[5:0];
  assign imm     = instruc[15:0];
  assign target  = instruc[25:0];

  assign sext_imm = {{16{imm[15]}}, imm};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : registerfile[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : registerfile[rt];

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], target, 2'b00};

  // One adder serves add and addi; one subtractor serves sub and slt.
  assign add_b    = (op == OP_ADDI) ? sext_imm : rt_val;
  assign add_full = {1'b0, rs_val} + {1'b0, add_b};
  assign sub_full = {1'b0, rs_val} - {1'b0, rt_val};
  assign add_v    = (rs_val[31] == add_b[31]) && (add_full[31] != rs_val[31]);
  assign sub_v    = (rs_val[31] != rt_val[31]) && (sub_full[31] != rs_val[31]);
  assign slt_bit  = sub_full[31] ^ sub_v;

  assign mem_addr = rs_val + sext_imm;
  assign dm_idx   = mem_addr[6:2];
  assign dm_rdata = datmem[dm_idx];

  // Decode and execute: next PC, write-back, store enable and status flags.
  always_comb begin
    pc_d     = pc_plus4;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = 32'd0;
    dm_we    = 1'b0;
    flag_upd = 1'b0;
    flag_res = 32'd0;
    flag_c   = 1'b0;
    flag_v   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = add_full[31:0];
            flag_upd = 1'b1;
            flag_res = add_full[31:0];
            flag_c   = add_full[32];
            flag_v   = add_v;
          end
          FN_SUB: begin
            rf_we    = 1'b1;
            rf_wdata = sub_full[31:0];
            flag_upd = 1'b1;
            flag_res = sub_full[31:0];
            flag_c   = sub_full[32];
            flag_v   = sub_v;
          end
          FN_SLT: begin
            rf_we    = 1'b1;
            rf_wdata = {31'd0, slt_bit};
            flag_upd = 1'b1;
            flag_res = {31'd0, slt_bit};
            flag_c   = sub_full[32];
            flag_v   = sub_v;
          end
          FN_AND: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val & rt_val;
          end
          FN_OR: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val | rt_val;
          end
          FN_NOR: begin
            rf_we    = 1'b1;
            rf_wdata = ~(rs_val | rt_val);
          end
          FN_JR:   pc_d = rs_val;
          default: ;
        endcase
      end
      OP_ADDI: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = add_full[31:0];
        flag_upd = 1'b1;
        flag_res = add_full[31:0];
        flag_c   = add_full[32];
        flag_v   = add_v;
      end
      OP_LW: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = dm_rdata;
      end
      OP_SW:  dm_we = 1'b1;
      OP_BEQ: if (rs_val == rt_val) pc_d = branch_target;
      OP_BNE: if (rs_val != rt_val) pc_d = branch_target;
      OP_J:   pc_d = jump_target;
      OP_JAL: begin
        pc_d     = jump_target;
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_plus4;
      end
      default: ;
    endcase
    status_d = flag_upd ? {flag_v, flag_c, flag_res[31], (flag_res == 32'd0)}
                        : statusregister;
  end

  // PC and status register commit; reset clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= 32'd0;
      statusregister <= 4'd0;
    end else begin
      pc             <= pc_d;
      statusregister <= status_d;
    end
  end

  // Register-file write port; $0 is never written and reset blocks writes.
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rf_waddr != 5'd0)) begin
      registerfile[rf_waddr] <= rf_wdata;
    end
  end

  // Data-memory store port; reset blocks stores.
  always_ff @(posedge clk) begin
    if (!reset && dm_we) begin
      datmem[dm_idx] <= rt_val;
    end
  end

endmodule

// File: tb/tb_datapath_processor.sv
// Directed program bench for datapath_processor: preloads memories, steps
// the core one instruction per cycle and compares architectural state.
module tb_datapath_processor;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  datapath_processor #(.IM_DEPTH(32), .DM_DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pc(input string tag, input logic [31:0] exp_pc);
    step();
    check(tag, dut.pc, exp_pc);
  endtask

  function automatic logic [31:0] st();
    return {28'd0, dut.statusregister};
  endfunction

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dut.instmem[i] = 32'h0000_0000;
      dut.datmem[i]  = 32'h0000_0000;
    end
    dut.registerfile[0] = 32'd0;
    dut.datmem[2] = 32'hDEAD_BEEF;
    dut.datmem[4] = 32'h7FFF_FFFF;
    dut.datmem[5] = 32'h1111_1111;

    dut.instmem[0]  = 32'h2001_0005; // 00 addi $1,$0,5
    dut.instmem[1]  = 32'h2002_0007; // 04 addi $2,$0,7
    dut.instmem[2]  = 32'h0021_2022; // 08 sub  $4,$1,$1
    dut.instmem[3]  = 32'hAC01_0014; // 0C sw   $1,20($0)
    dut.instmem[4]  = 32'h1021_0002; // 10 beq  $1,$1,+2
    dut.instmem[5]  = 32'h2021_0064; // 14 addi $1,$1,100 (skipped)
    dut.instmem[6]  = 32'h2021_0064; // 18 addi $1,$1,100 (skipped)
    dut.instmem[7]  = 32'h0800_0009; // 1C j    0x24
    dut.instmem[8]  = 32'h03E0_0008; // 20 jr   $31
    dut.instmem[9]  = 32'h0022_1820; // 24 add  $3,$1,$2
    dut.instmem[10] = 32'h0022_282A; // 28 slt  $5,$1,$2
    dut.instmem[11] = 32'h8C07_0008; // 2C lw   $7,8($0)
    dut.instmem[12] = 32'hAC07_000C; // 30 sw   $7,12($0)
    dut.instmem[13] = 32'h0022_0020; // 34 add  $0,$1,$2
    dut.instmem[14] = 32'h1421_0002; // 38 bne  $1,$1,+2
    dut.instmem[15] = 32'h8C0A_0010; // 3C lw   $10,16($0)
    dut.instmem[16] = 32'h2146_0001; // 40 addi $6,$10,1
    dut.instmem[17] = 32'h0C00_0008; // 44 jal  0x20
    dut.instmem[18] = 32'hFC21_0064; // 48 undefined opcode 0x3F
    dut.instmem[19] = 32'h8C0B_0088; // 4C lw   $11,0x88($0) wraps to word 2
    dut.instmem[20] = 32'h0800_0014; // 50 j    0x50 (park)

    step();
    step();
    check("rst_pc_initial", dut.pc, 32'h0);

    reset = 1'b0;
    step_pc("first_fetch_pc", 32'h4);
    check("first_fetch_r1", dut.registerfile[1], 32'd5);
    step_pc("pre_pc_08", 32'h8);
    step_pc("pre_pc_0c", 32'hC);
    check("pre_rst_status", st(), 32'h1);

    // Reset with PC at 0x0C: the sw there must not execute.
    reset = 1'b1;
    step();
    step();
    check("rst_pc", dut.pc, 32'h0);
    check("rst_status", st(), 32'h0);
    check("rst_no_store", dut.datmem[5], 32'h1111_1111);
    check("rst_no_regwr", dut.registerfile[1], 32'd5);

    reset = 1'b0;
    step_pc("pc_04", 32'h4);
    check("addi_r1", dut.registerfile[1], 32'd5);
    step_pc("pc_08", 32'h8);
    check("addi_r2", dut.registerfile[2], 32'd7);
    step_pc("pc_0c", 32'hC);
    check("sub_r4", dut.registerfile[4], 32'd0);
    check("sub_status_z", st(), 32'h1);
    step_pc("pc_10", 32'h10);
    check("sw_word5", dut.datmem[5], 32'd5);
    step_pc("beq_taken_pc", 32'h1C);
    step_pc("j_pc", 32'h24);
    check("beq_skip_r1", dut.registerfile[1], 32'd5);
    step_pc("pc_28", 32'h28);
    check("add_r3", dut.registerfile[3], 32'h0000_000C);
    check("add_status", st(), 32'h0);
    step_pc("pc_2c", 32'h2C);
    check("slt_r5", dut.registerfile[5], 32'd1);
    check("slt_status_c", st(), 32'h4);
    step_pc("pc_30", 32'h30);
    check("lw_r7", dut.registerfile[7], 32'hDEAD_BEEF);
    check("lw_status_hold", st(), 32'h4);
    step_pc("pc_34", 32'h34);
    check("sw_word3", dut.datmem[3], 32'hDEAD_BEEF);
    step_pc("pc_38", 32'h38);
    check("r0_stays_zero", dut.registerfile[0], 32'd0);
    check("add_r0_status", st(), 32'h0);
    step_pc("bne_not_taken_pc", 32'h3C);
    step_pc("pc_40", 32'h40);
    check("lw_r10", dut.registerfile[10], 32'h7FFF_FFFF);
    step_pc("pc_44", 32'h44);
    check("addi_ovf_r6", dut.registerfile[6], 32'h8000_0000);
    check("addi_ovf_status", st(), 32'hA);
    step_pc("jal_pc", 32'h20);
    check("jal_r31", dut.registerfile[31], 32'h48);
    step_pc("jr_pc", 32'h48);
    step_pc("nop_pc", 32'h4C);
    check("nop_r1", dut.registerfile[1], 32'd5);
    check("nop_status", st(), 32'hA);
    step_pc("pc_50", 32'h50);
    check("lw_wrap_r11", dut.registerfile[11], 32'hDEAD_BEEF);
    step_pc("park_pc", 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
